// File: rtl/pmod_bit_tx.sv
// -----------------------------------------------------------------------------
// pmod_bit_tx
// Serial bit-stream transmitter for one PMOD pin. It takes a parallel word over
// a valid/ready handshake and shifts it out MSB first. Each bit is held for
// DIV = CLK_FREQ/BIT_RATE clock cycles. After the frame the pin returns to the
// idle level 0, which matches the receiver's pulldown default.
//
// Optional feature macro: PMOD_BIT_TX_FRAMING_EN
//   When defined, each frame is a start bit (1), then WIDTH data bits, then a
//   stop bit (0). When undefined, only the raw WIDTH data bits are sent.
//
// Parameters:
//   CLK_FREQ : input clock frequency in Hz
//   BIT_RATE : bits per second on pmod_out
//   WIDTH    : data word width (>= 1)
//
// Ports:
//   clk_in   : sole clock, rising edge
//   rst_n    : synchronous reset, active low
//   tx_data  : word to send, sampled on accept
//   tx_valid : tx_data is valid
//   tx_ready : block can accept a word this cycle (registered)
//   pmod_out : serial line, idle 0 (registered)
//   busy     : frame in progress (registered)
//   tx_done  : one-cycle pulse when a frame completes (registered)
// -----------------------------------------------------------------------------
module pmod_bit_tx #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BIT_RATE = 1,
   parameter int WIDTH    = 8
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             pmod_out,
   output logic             busy,
   output logic             tx_done
);

   localparam int DIV = CLK_FREQ / BIT_RATE;
`ifdef PMOD_BIT_TX_FRAMING_EN
   localparam int NBITS = WIDTH + 2;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

   // Refuse to elaborate with a bit period shorter than one clock or an
   // empty data word.
   generate
      if (DIV < 1) begin : g_bad_div
         $error("pmod_bit_tx: CLK_FREQ/BIT_RATE must be at least 1");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("pmod_bit_tx: WIDTH must be at least 1");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [NBITS-1:0] shreg, shreg_n;
   logic [DIV_W-1:0] div_cnt, div_cnt_n;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
   logic             tx_ready_n, pmod_out_n, busy_n, tx_done_n;
   logic [NBITS-1:0] frame;

   // Frame as it will appear on the line, first bit in the MSB position.
   // The start bit guarantees a visible rising edge even for an all-zero word.
   always_comb begin
`ifdef PMOD_BIT_TX_FRAMING_EN
      frame = {1'b1, tx_data, 1'b0};
`else
      frame = tx_data;
`endif
   end

   // State and output registers. Every output is a flop, so there is no
   // combinational path from the inputs to the pin or the status signals.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_ready <= 1'b0;
         pmod_out <= 1'b0;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         div_cnt  <= div_cnt_n;
         bit_cnt  <= bit_cnt_n;
         tx_ready <= tx_ready_n;
         pmod_out <= pmod_out_n;
         busy     <= busy_n;
         tx_done  <= tx_done_n;
      end
   end

   // Next-state logic. The output values are computed one cycle ahead, so the
   // registered outputs change on the same edge as the state.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      div_cnt_n  = div_cnt;
      bit_cnt_n  = bit_cnt;
      tx_ready_n = tx_ready;
      pmod_out_n = pmod_out;
      busy_n     = busy;
      tx_done_n  = 1'b0;

      case (state)
         IDLE: begin
            tx_ready_n = 1'b1;
            pmod_out_n = 1'b0;
            busy_n     = 1'b0;
            // Accept requires the registered ready, so the first edge after
            // reset only raises tx_ready and never takes a word.
            if (tx_valid && tx_ready) begin
               state_n    = SEND;
               shreg_n    = frame;
               div_cnt_n  = '0;
               bit_cnt_n  = '0;
               tx_ready_n = 1'b0;
               busy_n     = 1'b1;
               pmod_out_n = frame[NBITS-1];
            end
         end
         SEND: begin
            tx_ready_n = 1'b0;
            busy_n     = 1'b1;
            if (div_cnt == DIV_W'(DIV - 1)) begin
               div_cnt_n = '0;
               if (bit_cnt == BIT_W'(NBITS - 1)) begin
                  state_n    = IDLE;
                  bit_cnt_n  = '0;
                  pmod_out_n = 1'b0;
                  tx_ready_n = 1'b1;
                  busy_n     = 1'b0;
                  tx_done_n  = 1'b1;
               end else begin
                  bit_cnt_n  = bit_cnt + BIT_W'(1);
                  shreg_n    = shreg << 1;
                  pmod_out_n = shreg_n[NBITS-1];
               end
            end else begin
               div_cnt_n = div_cnt + DIV_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pmod_bit_tx.sv
// -----------------------------------------------------------------------------
// tb_pmod_bit_tx
// Self-checking bench for pmod_bit_tx with CLK_FREQ=8, BIT_RATE=2 (DIV=4) and
// WIDTH=4. A reference model predicts the line level and status outputs after
// every clock edge. It expands each accepted word into the list of line samples
// the frame should produce. Directed sequences cover reset, a single frame,
// back-to-back frames, a mid-frame reset and input changes during a frame.
// These are followed by a randomized run.
// Honours PMOD_BIT_TX_FRAMING_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pmod_bit_tx;

   localparam int TbWidth = 4;
   localparam int TbDiv   = 8 / 2;
`ifdef PMOD_BIT_TX_FRAMING_EN
   localparam int TbBits  = TbWidth + 2;
`else
   localparam int TbBits  = TbWidth;
`endif
   localparam int FrameCycles = TbBits * TbDiv;

   logic               clk;
   logic               rst_n;
   logic [TbWidth-1:0] tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               pmod_out;
   logic               busy;
   logic               tx_done;

   int testCount = 0;
   int failCount = 0;
   int cycleNum  = 0;

   pmod_bit_tx #(
      .CLK_FREQ (8),
      .BIT_RATE (2),
      .WIDTH    (TbWidth)
   ) dut (
      .clk_in   (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .pmod_out (pmod_out),
      .busy     (busy),
      .tx_done  (tx_done)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an accepted word becomes a queue of line samples, one
   // per clock. Each frame bit is repeated DIV times, first bit first. The
   // queue head is the level visible after the current edge. When the last
   // sample is consumed the line idles, ready returns and done pulses.
   bit   expQ[$];
   logic mPmod, mBusy, mReady, mDone;
   int   acceptCount = 0;

   function automatic void loadFrame(input logic [TbWidth-1:0] word);
      bit bits[$];
      expQ.delete();
`ifdef PMOD_BIT_TX_FRAMING_EN
      bits.push_back(1'b1);
`endif
      for (int i = TbWidth - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef PMOD_BIT_TX_FRAMING_EN
      bits.push_back(1'b0);
`endif
      foreach (bits[i])
         for (int k = 0; k < TbDiv; k++) expQ.push_back(bits[i]);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         expQ.delete();
         mPmod  = 1'b0;
         mBusy  = 1'b0;
         mReady = 1'b0;
         mDone  = 1'b0;
      end else if (expQ.size() > 0) begin
         void'(expQ.pop_front());
         mDone = 1'b0;
         if (expQ.size() == 0) begin
            mPmod  = 1'b0;
            mBusy  = 1'b0;
            mReady = 1'b1;
            mDone  = 1'b1;
         end else begin
            mPmod = expQ[0];
         end
      end else begin
         mDone = 1'b0;
         if (tx_valid && mReady) begin
            loadFrame(tx_data);
            acceptCount++;
            mPmod  = expQ[0];
            mBusy  = 1'b1;
            mReady = 1'b0;
         end else begin
            mPmod  = 1'b0;
            mBusy  = 1'b0;
            mReady = 1'b1;
         end
      end
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s (cycle %0d): got 'h%0h, expected 'h%0h",
                  tag, cycleNum, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [TbWidth-1:0] data);
      tx_valid = valid;
      tx_data  = data;
   endtask

   // Advance one clock, then compare every output with the model away from the edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      cycleNum++;
      checkOutput("pmod_out", 64'(pmod_out), 64'(mPmod));
      checkOutput("busy",     64'(busy),     64'(mBusy));
      checkOutput("tx_ready", 64'(tx_ready), 64'(mReady));
      checkOutput("tx_done",  64'(tx_done),  64'(mDone));
   endtask

   task automatic idleCycles(input int n);
      applyStimulus(1'b0, tx_data);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Overall time guard.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] capPmod;
      logic [63:0] capDone;
      logic [63:0] expPmod;
      logic [63:0] expDone;
      logic [TbWidth-1:0] firstWord;
      int startAcc;
      int doneStep;
      int acceptStep;

      // Reset with tx_valid high: no accept, all outputs low.
`ifdef PMOD_BIT_TX_FRAMING_EN
      firstWord = 4'b0000;
      expPmod   = 64'h000000F;
`else
      firstWord = 4'b1011;
      expPmod   = 64'h0FF0F;
`endif
      expDone = 64'd1 << FrameCycles;
      rst_n = 1'b0;
      applyStimulus(1'b1, firstWord);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("reset_ready", 64'(tx_ready), 64'd0);
      end
      rst_n = 1'b1;
      stepCycle();
      checkOutput("ready_after_release", 64'(tx_ready), 64'd1);
      checkOutput("no_accept_on_release", 64'(busy), 64'd0);

      // Single frame: capture the line for FrameCycles+1 edges starting at accept.
      capPmod = '0;
      capDone = '0;
      for (int j = 0; j <= FrameCycles; j++) begin
         stepCycle();
         capPmod[j] = pmod_out;
         capDone[j] = tx_done;
         if (j == 0) applyStimulus(1'b0, 4'b0101);
      end
      checkOutput("single_frame_line", capPmod, expPmod);
      checkOutput("single_frame_done", capDone, expDone);
      idleCycles(2);

      // Back-to-back with tx_valid held high.
      startAcc   = acceptCount;
      doneStep   = -1;
      acceptStep = -1;
      applyStimulus(1'b1, 4'b1000);
      stepCycle();
      applyStimulus(1'b1, 4'b0001);
      for (int i = 1; i < 4 * FrameCycles && acceptStep < 0; i++) begin
         stepCycle();
         if (tx_done && doneStep < 0) doneStep = i;
         if (acceptCount == startAcc + 2) acceptStep = i;
      end
      applyStimulus(1'b0, 4'b0000);
      checkOutput("b2b_second_accept", 64'(acceptCount - startAcc), 64'd2);
      checkOutput("b2b_accept_after_done", 64'(acceptStep), 64'(doneStep + 1));
      idleCycles(FrameCycles + 3);

      // Reset during a 1111 frame, then a 0110 frame afterwards.
      applyStimulus(1'b1, 4'b1111);
      stepCycle();
      applyStimulus(1'b0, 4'b1111);
      for (int i = 0; i < 5; i++) stepCycle();
      rst_n = 1'b0;
      stepCycle();
      checkOutput("midreset_pmod", 64'(pmod_out), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      stepCycle();
      applyStimulus(1'b1, 4'b0110);
      stepCycle();
      applyStimulus(1'b0, 4'b0000);
      for (int i = 0; i < FrameCycles + 2; i++) stepCycle();

      // Stability: data and valid change every cycle during the frame.
      applyStimulus(1'b1, 4'($urandom));
      stepCycle();
      for (int i = 0; i < FrameCycles - 1; i++) begin
         applyStimulus(~tx_valid, 4'($urandom));
         stepCycle();
         checkOutput("stable_ready_low", 64'(tx_ready), 64'd0);
      end
      idleCycles(FrameCycles + 3);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom));
         stepCycle();
      end
      rst_n = 1'b1;
      idleCycles(FrameCycles + 3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
